ahb_dma_req_sync: RTL and testbench

Per-channel peripheral DMA request front end. It sits directly upstream of the DMA channel-select stage:
- Synchronises asynchronous peripheral source/destination request lines into clk.
- Converts level- or edge-signalled requests into one-deep pending requests (req_o feeds channel-select req_i; dst_req_o feeds dma_dst_req).
- Turns channel-select ack pulses into stretched peripheral acknowledges.
- Flags request overruns.

---
 rtl/ahb_dma_req_sync_pkg.sv | 18 +
 rtl/ahb_dma_req_sync_if.sv | 46 ++++
 rtl/ahb_dma_req_sync_ch.sv | 128 ++++++++++++
 rtl/ahb_dma_req_sync.sv | 47 ++++
 tb/tb_ahb_dma_req_sync.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/ahb_dma_req_sync_pkg.sv
// ----------------------------------------------------------------------------
// ahb_dma_req_pkg
// Shared types and constants for the peripheral DMA request front end.
//   req_state_t : per-channel request FSM state
//   ACK_CNT_W   : width of the acknowledge stretch counter (covers 1..7)
// ----------------------------------------------------------------------------
package ahb_dma_req_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        ACK  = 2'd2,
        DROP = 2'd3
    } req_state_t;

    localparam int ACK_CNT_W = $clog2(8);

endpackage

// File: rtl/ahb_dma_req_sync_if.sv
// ----------------------------------------------------------------------------
// ahb_dma_req_sync_if
// Bundles the per-channel request/acknowledge lines of the DMA request front
// end. One bit per channel on every vector.
//   master : peripheral/CSR/channel-select side (drives requests, enables,
//            ack pulses, overrun clears; observes outputs)
//   slave  : ahb_dma_req_sync itself
//
// Handshake: req_o[ch] is a one-deep pending request. It stays high until
// channel select returns a single-cycle ack_i[ch]; req_o[ch] drops the cycle
// after that ack is sampled and periph_ack[ch] is then held for the stretch
// period. ack_i[ch] while req_o[ch] is low has no effect.
//
// dbg_state exposes each channel FSM state for observation.
// ----------------------------------------------------------------------------
interface ahb_dma_req_sync_if
    import ahb_dma_req_pkg::*;
#(
    parameter int channel_number = 15
) ();

    logic [channel_number-1:0] periph_src_req;
    logic [channel_number-1:0] periph_dst_req;
    logic [channel_number-1:0] ch_en;
    logic [channel_number-1:0] ch_edge_mode;
    logic [channel_number-1:0] ack_i;
    logic [channel_number-1:0] overrun_clr;
    logic [channel_number-1:0] req_o;
    logic [channel_number-1:0] dst_req_o;
    logic [channel_number-1:0] periph_ack;
    logic [channel_number-1:0] overrun;
    req_state_t                dbg_state [channel_number];

    modport master (
        output periph_src_req, periph_dst_req, ch_en, ch_edge_mode,
               ack_i, overrun_clr,
        input  req_o, dst_req_o, periph_ack, overrun, dbg_state
    );

    modport slave (
        input  periph_src_req, periph_dst_req, ch_en, ch_edge_mode,
               ack_i, overrun_clr,
        output req_o, dst_req_o, periph_ack, overrun, dbg_state
    );

endinterface

// File: rtl/ahb_dma_req_sync_ch.sv
// ----------------------------------------------------------------------------
// ahb_dma_req_sync_ch
// One DMA request channel: synchronisers for source/destination request,
// source edge detect, request FSM with acknowledge stretch, sticky overrun.
// Ports:
//   clk, rst      : clock, asynchronous active-low reset
//   src_req       : async source request from peripheral
//   dst_req       : async destination request from peripheral
//   en            : channel enable
//   edge_mode     : 1 = rising-edge request, 0 = level request
//   ack_in        : single-cycle ack from channel select
//   ovr_clr       : clears sticky overrun
//   req           : pending source request (high in PEND)
//   dst_req_out   : registered synchronised destination request
//   periph_ack    : stretched acknowledge to peripheral (high in ACK)
//   overrun       : sticky overrun flag
//   state_dbg     : current FSM state
// ----------------------------------------------------------------------------
module ahb_dma_req_sync_ch
    import ahb_dma_req_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int ACK_STRETCH = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       src_req,
    input  logic       dst_req,
    input  logic       en,
    input  logic       edge_mode,
    input  logic       ack_in,
    input  logic       ovr_clr,
    output logic       req,
    output logic       dst_req_out,
    output logic       periph_ack,
    output logic       overrun,
    output req_state_t state_dbg
);

    logic [SYNC_STAGES-1:0] src_sync_q, src_sync_d;
    logic [SYNC_STAGES-1:0] dst_sync_q, dst_sync_d;
    logic                   src_prev_q, src_prev_d;
    logic                   dst_req_q, dst_req_d;
    logic                   overrun_q, overrun_d;
    logic [ACK_CNT_W-1:0]   cnt_q, cnt_d;
    req_state_t             state_q, state_d;

    logic src_s;
    logic dst_s;
    logic src_evt;

    assign src_s = src_sync_q[SYNC_STAGES-1];
    assign dst_s = dst_sync_q[SYNC_STAGES-1];

    always_comb begin
        src_sync_d = {src_sync_q[SYNC_STAGES-2:0], src_req};
        dst_sync_d = {dst_sync_q[SYNC_STAGES-2:0], dst_req};
        src_prev_d = src_s;
        dst_req_d  = dst_s & en;
        src_evt    = edge_mode ? (src_s & ~src_prev_q) : src_s;

        state_d    = state_q;
        cnt_d      = cnt_q;
        overrun_d  = overrun_q;

        case (state_q)
            IDLE: begin
                if (src_evt && en) state_d = PEND;
            end
            PEND: begin
                // ack wins over a same-cycle disable
                if (ack_in) begin
                    state_d = ACK;
                    cnt_d   = '0;
                end else if (!en) begin
                    state_d = IDLE;
                end
            end
            ACK: begin
                // stretch always runs to completion regardless of en
                if (cnt_q == ACK_CNT_W'(ACK_STRETCH - 1)) begin
                    state_d = edge_mode ? IDLE : DROP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ACK_CNT_W'(1);
                end
            end
            DROP: begin
                // level request must be seen low before it can re-arm
                if (!src_s || !en) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // an edge while a request is outstanding is lost, not queued
        if (edge_mode && src_evt && (state_q == PEND || state_q == ACK))
            overrun_d = 1'b1;
        if (ovr_clr)
            overrun_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            src_sync_q <= '0;
            dst_sync_q <= '0;
            src_prev_q <= 1'b0;
            dst_req_q  <= 1'b0;
            overrun_q  <= 1'b0;
            cnt_q      <= '0;
            state_q    <= IDLE;
        end else begin
            src_sync_q <= src_sync_d;
            dst_sync_q <= dst_sync_d;
            src_prev_q <= src_prev_d;
            dst_req_q  <= dst_req_d;
            overrun_q  <= overrun_d;
            cnt_q      <= cnt_d;
            state_q    <= state_d;
        end
    end

    assign req         = (state_q == PEND);
    assign periph_ack  = (state_q == ACK);
    assign dst_req_out = dst_req_q;
    assign overrun     = overrun_q;
    assign state_dbg   = state_q;

endmodule

// File: rtl/ahb_dma_req_sync.sv
// ----------------------------------------------------------------------------
// ahb_dma_req_sync
// Per-channel peripheral DMA request front end feeding channel select.
// Ports:
//   clk  : clock
//   rst  : asynchronous active-low reset
//   bus  : ahb_dma_req_sync_if.slave (request/ack/enable/overrun vectors and
//          per-channel state observation)
// Parameters:
//   channel_number : number of channels (1..31)
//   SYNC_STAGES    : synchroniser depth (2..3)
//   ACK_STRETCH    : periph_ack high time in cycles (1..7)
// ----------------------------------------------------------------------------
module ahb_dma_req_sync
    import ahb_dma_req_pkg::*;
#(
    parameter int channel_number = 15,
    parameter int SYNC_STAGES    = 2,
    parameter int ACK_STRETCH    = 2
) (
    input logic                clk,
    input logic                rst,
    ahb_dma_req_sync_if.slave  bus
);

    for (genvar i = 0; i < channel_number; i++) begin : g_ch
        ahb_dma_req_sync_ch #(
            .SYNC_STAGES (SYNC_STAGES),
            .ACK_STRETCH (ACK_STRETCH)
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .src_req     (bus.periph_src_req[i]),
            .dst_req     (bus.periph_dst_req[i]),
            .en          (bus.ch_en[i]),
            .edge_mode   (bus.ch_edge_mode[i]),
            .ack_in      (bus.ack_i[i]),
            .ovr_clr     (bus.overrun_clr[i]),
            .req         (bus.req_o[i]),
            .dst_req_out (bus.dst_req_o[i]),
            .periph_ack  (bus.periph_ack[i]),
            .overrun     (bus.overrun[i]),
            .state_dbg   (bus.dbg_state[i])
        );
    end

endmodule

// File: tb/tb_ahb_dma_req_sync.sv
module tb_ahb_dma_req_sync;
  import ahb_dma_req_pkg::*;

  localparam int N = 15;

  // clock / reset
  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ahb_dma_req_sync_if #(.channel_number(N)) bus ();

  ahb_dma_req_sync #(
    .channel_number (N),
    .SYNC_STAGES    (2),
    .ACK_STRETCH    (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors;
  int miscompares;

  // driver: advance one clock and settle just after the edge
  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // scoreboard checks
  task automatic chk(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_v(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_st(input string tag, input req_state_t obs, input req_state_t exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst = 1'b0;
    bus.periph_src_req = '0;
    bus.periph_dst_req = '0;
    bus.ch_en          = '1;
    bus.ch_edge_mode   = 15'h0008;   // ch3 edge, rest level
    bus.ack_i          = '0;
    bus.overrun_clr    = '0;

    // reset state
    #23;
    chk_v("rst_req_o", bus.req_o, '0);
    chk_v("rst_periph_ack", bus.periph_ack, '0);
    chk_v("rst_overrun", bus.overrun, '0);
    chk_v("rst_dst_req_o", bus.dst_req_o, '0);
    chk_st("rst_state0", bus.dbg_state[0], IDLE);
    @(posedge clk);
    #1 rst = 1'b1;
    step(2);

    // ---- level handshake ch0 ----
    bus.periph_src_req[0] = 1'b1;
    step(2);
    chk("lvl_req_lat2", bus.req_o[0], 1'b0);
    step(1);
    chk("lvl_req_lat3", bus.req_o[0], 1'b1);
    step(3);
    chk("lvl_req_hold", bus.req_o[0], 1'b1);
    chk("lvl_noack_pend", bus.periph_ack[0], 1'b0);
    bus.ack_i[0] = 1'b1;
    step(1);
    bus.ack_i[0] = 1'b0;
    chk("lvl_req_after_ack", bus.req_o[0], 1'b0);
    chk("lvl_pack_c1", bus.periph_ack[0], 1'b1);
    step(1);
    chk("lvl_pack_c2", bus.periph_ack[0], 1'b1);
    step(1);
    chk("lvl_pack_end", bus.periph_ack[0], 1'b0);
    chk_st("lvl_drop", bus.dbg_state[0], DROP);
    step(4);
    chk("lvl_no_rereq", bus.req_o[0], 1'b0);
    chk_st("lvl_drop_hold", bus.dbg_state[0], DROP);
    bus.periph_src_req[0] = 1'b0;
    step(3);
    chk_st("lvl_idle_after_low", bus.dbg_state[0], IDLE);
    bus.periph_src_req[0] = 1'b1;
    step(2);
    chk("lvl_rereq_lat2", bus.req_o[0], 1'b0);
    step(1);
    chk("lvl_rereq_lat3", bus.req_o[0], 1'b1);
    bus.ch_en[0] = 1'b0;
    bus.periph_src_req[0] = 1'b0;
    step(4);
    bus.ch_en[0] = 1'b1;

    // ---- ack_i ignored in IDLE (ch4) ----
    bus.ack_i[4] = 1'b1;
    step(1);
    bus.ack_i[4] = 1'b0;
    chk_st("idle_ack_ignored", bus.dbg_state[4], IDLE);
    chk("idle_ack_no_pack", bus.periph_ack[4], 1'b0);

    // ---- edge mode with overrun ch3 ----
    bus.periph_src_req[3] = 1'b1;
    step(3);
    chk("edge_req", bus.req_o[3], 1'b1);
    bus.periph_src_req[3] = 1'b0;
    step(3);
    chk("edge_req_held", bus.req_o[3], 1'b1);
    bus.periph_src_req[3] = 1'b1;
    step(2);
    chk("edge_ovr_lat2", bus.overrun[3], 1'b0);
    step(1);
    chk("edge_ovr_set", bus.overrun[3], 1'b1);
    chk_st("edge_still_pend", bus.dbg_state[3], PEND);
    bus.ack_i[3] = 1'b1;
    step(1);
    bus.ack_i[3] = 1'b0;
    chk("edge_pack_c1", bus.periph_ack[3], 1'b1);
    step(1);
    chk("edge_pack_c2", bus.periph_ack[3], 1'b1);
    step(1);
    chk("edge_pack_end", bus.periph_ack[3], 1'b0);
    chk_st("edge_idle", bus.dbg_state[3], IDLE);
    step(3);
    chk("edge_not_queued", bus.req_o[3], 1'b0);
    bus.ch_en[3] = 1'b0;
    step(1);
    chk("edge_ovr_hold_en", bus.overrun[3], 1'b1);
    bus.ch_en[3] = 1'b1;
    bus.overrun_clr[3] = 1'b1;
    step(1);
    bus.overrun_clr[3] = 1'b0;
    chk("edge_ovr_clr", bus.overrun[3], 1'b0);
    bus.periph_src_req[3] = 1'b0;
    step(3);

    // ---- enable drop in PEND ch5 ----
    bus.periph_src_req[5] = 1'b1;
    step(3);
    chk("en_req", bus.req_o[5], 1'b1);
    bus.ch_en[5] = 1'b0;
    step(1);
    chk("en_drop_req", bus.req_o[5], 1'b0);
    chk_st("en_drop_idle", bus.dbg_state[5], IDLE);
    for (int k = 0; k < 3; k++) begin
      step(1);
      chk("en_drop_no_pack", bus.periph_ack[5], 1'b0);
    end
    bus.periph_src_req[5] = 1'b0;
    step(3);
    bus.ch_en[5] = 1'b1;

    // ---- simultaneous ack and disable ch2 ----
    bus.periph_src_req[2] = 1'b1;
    step(3);
    chk("sim_req", bus.req_o[2], 1'b1);
    bus.ack_i[2] = 1'b1;
    bus.ch_en[2] = 1'b0;
    step(1);
    bus.ack_i[2] = 1'b0;
    chk("sim_pack_c1", bus.periph_ack[2], 1'b1);
    step(1);
    chk("sim_pack_c2", bus.periph_ack[2], 1'b1);
    step(1);
    chk("sim_pack_end", bus.periph_ack[2], 1'b0);
    step(1);
    chk_st("sim_idle", bus.dbg_state[2], IDLE);
    bus.periph_src_req[2] = 1'b0;
    step(3);
    bus.ch_en[2] = 1'b1;

    // ---- destination path ch7 ----
    bus.periph_dst_req[7] = 1'b1;
    step(2);
    chk("dst_lat2", bus.dst_req_o[7], 1'b0);
    step(1);
    chk("dst_lat3", bus.dst_req_o[7], 1'b1);
    chk_v("dst_only_ch7", bus.dst_req_o, 15'h0080);
    bus.ch_en[7] = 1'b0;
    step(1);
    chk("dst_en_off", bus.dst_req_o[7], 1'b0);
    bus.periph_dst_req[7] = 1'b0;
    bus.ch_en[7] = 1'b1;
    step(3);

    // ---- async reset mid-ACK ch1 ----
    bus.periph_src_req[1] = 1'b1;
    step(3);
    chk("rst_ch1_req", bus.req_o[1], 1'b1);
    bus.ack_i[1] = 1'b1;
    step(1);
    bus.ack_i[1] = 1'b0;
    chk("rst_ch1_pack", bus.periph_ack[1], 1'b1);
    #2 rst = 1'b0;
    #1;
    chk_v("arst_periph_ack", bus.periph_ack, '0);
    chk_v("arst_req_o", bus.req_o, '0);
    chk_v("arst_overrun", bus.overrun, '0);
    chk_st("arst_state1", bus.dbg_state[1], IDLE);
    @(posedge clk);
    #1 rst = 1'b1;
    step(2);
    chk("rel_lat2", bus.req_o[1], 1'b0);
    step(1);
    chk("rel_lat3", bus.req_o[1], 1'b1);
    chk_st("rel_pend", bus.dbg_state[1], PEND);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
